alu_op_issuer: RTL and testbench

- Upstream feeder for ALU_DESIGN: buffers complete operation requests in a small FIFO and replays each one onto the ALU input bus (OPA/OPB/CMD/MODE/CIN/CE/INP_VALID).
- Either both operands go in one beat (INP_VALID=11), or in split mode as two beats (01, then 10).
- Pads each op with the ALU's result latency and raises RES_STROBE in the cycle the ALU result is valid, so the downstream monitor/scoreboard samples RES and flags without tracking latency itself.

---
 rtl/alu_op_issuer.sv | 196 +++++++++++++++++++
 tb/tb_alu_op_issuer.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// Request FIFO plus issue sequencer feeding an ALU: replays each buffered op as one
// full-operand beat or two split beats, then pulses res_strobe_o when the ALU result is valid.
module alu_op_issuer #(
  parameter int DW      = 8,
  parameter int CW      = 4,
  parameter int DEPTH   = 4,
  parameter int STD_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DW-1:0]           in_opa_i,
  input  logic [DW-1:0]           in_opb_i,
  input  logic [CW-1:0]           in_cmd_i,
  input  logic                    in_mode_i,
  input  logic                    in_cin_i,
  input  logic                    in_split_i,
  output logic [DW-1:0]           opa_o,
  output logic [DW-1:0]           opb_o,
  output logic [CW-1:0]           cmd_o,
  output logic                    mode_o,
  output logic                    cin_o,
  output logic                    ce_o,
  output logic [1:0]              inp_valid_o,
  output logic                    res_strobe_o,
  output logic                    busy_o,
  output logic [$clog2(DEPTH):0]  fifo_cnt_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int MAX_LAT = (MUL_LAT > STD_LAT) ? MUL_LAT : STD_LAT;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SPLIT_A,
    S_SPLIT_B,
    S_WAIT
  } state_e;

  typedef struct packed {
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic [CW-1:0] cmd;
    logic          mode;
    logic          cin;
    logic          split;
  } req_t;

  // ---------------------------------------------------------------- request FIFO
  req_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             push, pop;
  req_t             in_req, head;

  assign in_req = '{opa: in_opa_i, opb: in_opb_i, cmd: in_cmd_i,
                    mode: in_mode_i, cin: in_cin_i, split: in_split_i};
  assign in_ready_o = (cnt_q != FULL_CNT);
  assign push       = in_valid_i & in_ready_o;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_cnt_o = cnt_q;

  // NOTE: the storage array has no reset; pointers and count gate every read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_req;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------- sequencer
  state_e           state_q, state_d;
  logic [LAT_W-1:0] wcnt_q, wcnt_d;
  logic [DW-1:0]    opa_q, opa_d, opb_q, opb_d;
  logic [CW-1:0]    cmd_q, cmd_d;
  logic             mode_q, mode_d, cin_q, cin_d, ce_q, ce_d, strobe_q, strobe_d;
  logic [1:0]       iv_q, iv_d;
  logic             head_is_mul;
  logic [LAT_W-1:0] head_lat_m1;

  assign head_is_mul = head.mode && ((head.cmd == CW'(9)) || (head.cmd == CW'(10)));
  // wcnt counts the WAIT cycles still to come after the current one; the strobe
  // lands on the LAT-th cycle after the final issue beat.
  assign head_lat_m1 = head_is_mul ? LAT_W'(MUL_LAT - 1) : LAT_W'(STD_LAT - 1);

  // NOTE: every signal assigned below gets a default first, so no latch can be inferred.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cmd_d    = cmd_q;
    mode_d   = mode_q;
    cin_d    = cin_q;
    ce_d     = 1'b0;
    iv_d     = 2'b00;
    strobe_d = 1'b0;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          opa_d  = head.opa;
          cmd_d  = head.cmd;
          mode_d = head.mode;
          cin_d  = head.cin;
          ce_d   = 1'b1;
          if (head.split) begin
            state_d = S_SPLIT_A;
            iv_d    = 2'b01;
          end else begin
            state_d = S_ISSUE;
            opb_d   = head.opb;
            iv_d    = 2'b11;
          end
        end
      end
      S_SPLIT_A: begin
        state_d = S_SPLIT_B;
        opb_d   = head.opb;
        ce_d    = 1'b1;
        iv_d    = 2'b10;
      end
      S_ISSUE, S_SPLIT_B: begin
        pop      = 1'b1;
        state_d  = S_WAIT;
        wcnt_d   = head_lat_m1;
        strobe_d = (head_lat_m1 == '0);
      end
      S_WAIT: begin
        if (wcnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          wcnt_d   = wcnt_q - LAT_W'(1);
          strobe_d = (wcnt_q == LAT_W'(1));
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cmd_q    <= '0;
      mode_q   <= 1'b0;
      cin_q    <= 1'b0;
      ce_q     <= 1'b0;
      iv_q     <= 2'b00;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cmd_q    <= cmd_d;
      mode_q   <= mode_d;
      cin_q    <= cin_d;
      ce_q     <= ce_d;
      iv_q     <= iv_d;
      strobe_q <= strobe_d;
    end
  end

  assign opa_o        = opa_q;
  assign opb_o        = opb_q;
  assign cmd_o        = cmd_q;
  assign mode_o       = mode_q;
  assign cin_o        = cin_q;
  assign ce_o         = ce_q;
  assign inp_valid_o  = iv_q;
  assign res_strobe_o = strobe_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer: directed scenarios plus randomized traffic, scored against
// an in-order queue of requests and the latency rule derived from each request.
module tb_alu_op_issuer;
  typedef struct packed {
    logic [7:0] opa;
    logic [7:0] opb;
    logic [3:0] cmd;
    logic       mode;
    logic       cin;
    logic       split;
  } req_t;

  typedef struct {
    req_t r;
    int   lat;
    int   gap;
    int   first_cyc;
    bit   opb_held;
    bit   opa_held;
    bit   held_at_strobe;
  } obs_t;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 1'b0, in_mode = 1'b0, in_cin = 1'b0, in_split = 1'b0;
  logic [7:0] in_opa = '0, in_opb = '0;
  logic [3:0] in_cmd = '0;
  logic       in_ready, mode, cin, ce, strobe, busy;
  logic [7:0] opa, opb;
  logic [3:0] cmd;
  logic [1:0] iv;
  logic [2:0] fifo_cnt;

  int   checks = 0, errors = 0, cyc = 0;
  req_t model_q[$];
  obs_t obs_q[$];

  alu_op_issuer #(.DW(8), .CW(4), .DEPTH(4), .STD_LAT(1), .MUL_LAT(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_opa_i(in_opa), .in_opb_i(in_opb), .in_cmd_i(in_cmd), .in_mode_i(in_mode),
    .in_cin_i(in_cin), .in_split_i(in_split), .opa_o(opa), .opb_o(opb), .cmd_o(cmd),
    .mode_o(mode), .cin_o(cin), .ce_o(ce), .inp_valid_o(iv), .res_strobe_o(strobe),
    .busy_o(busy), .fifo_cnt_o(fifo_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input req_t r);
    return (r.mode && (r.cmd == 4'd9 || r.cmd == 4'd10)) ? 2 : 1;
  endfunction

  // Only the two commands the directed tests use: mode 1 cmd 0 = ADD, mode 0 cmd 0 = AND.
  function automatic logic [7:0] alu_res(input logic [7:0] a, input logic [7:0] b, input logic m);
    return m ? a + b : a & b;
  endfunction

  function automatic req_t rand_req(input bit allow_split, input bit allow_mul);
    req_t r;
    r.opa   = 8'($urandom);
    r.opb   = 8'($urandom);
    r.cmd   = 4'($urandom_range(0, 15));
    r.mode  = 1'($urandom);
    r.cin   = 1'($urandom);
    r.split = allow_split ? 1'($urandom) : 1'b0;
    if (allow_mul && $urandom_range(0, 3) == 0) begin
      r.mode = 1'b1;
      r.cmd  = 4'($urandom_range(9, 10));
    end
    if (!allow_mul && r.mode && (r.cmd == 4'd9 || r.cmd == 4'd10)) r.cmd = 4'd0;
    return r;
  endfunction

  // Passive bus recorder: rebuilds each op from its beats and times its strobe.
  bit         pending = 0, a_seen = 0;
  int         a_cyc = 0, last_beat_cyc = 0, last_strobe_cyc = -1000;
  int         beat_cnt = 0, bad_bus = 0, stray_strobe = 0;
  logic [7:0] prev_opb = '0;
  obs_t       cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 0;
      a_seen = 0;
      last_strobe_cyc = -1000;
    end else begin
      if (ce) beat_cnt++;
      if (ce && iv === 2'b11) begin
        cur.r = '{opa: opa, opb: opb, cmd: cmd, mode: mode, cin: cin, split: 1'b0};
        cur.first_cyc = cyc; cur.gap = cyc - last_strobe_cyc;
        cur.opb_held = 1; cur.opa_held = 1;
        last_beat_cyc = cyc; pending = 1;
      end else if (ce && iv === 2'b01) begin
        cur.r = '{opa: opa, opb: 8'h00, cmd: cmd, mode: mode, cin: cin, split: 1'b1};
        cur.first_cyc = cyc; cur.gap = cyc - last_strobe_cyc;
        cur.opb_held = (opb === prev_opb);
        a_seen = 1; a_cyc = cyc;
      end else if (ce && iv === 2'b10) begin
        if (!a_seen || cyc != a_cyc + 1) bad_bus++;
        cur.opa_held = (opa === cur.r.opa && cmd === cur.r.cmd && mode === cur.r.mode && cin === cur.r.cin);
        cur.r.opb = opb; last_beat_cyc = cyc; pending = 1; a_seen = 0;
      end else if (ce || iv !== 2'b00) begin
        bad_bus++;
      end
      if (strobe) begin
        if (!pending) stray_strobe++;
        else begin
          cur.lat = cyc - last_beat_cyc;
          cur.held_at_strobe = (opa === cur.r.opa && opb === cur.r.opb && cmd === cur.r.cmd &&
                                mode === cur.r.mode && cin === cur.r.cin);
          obs_q.push_back(cur);
          pending = 0;
          last_strobe_cyc = cyc;
        end
      end
    end
    prev_opb = opb;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Holds the request on the bus until a cycle with in_ready high has clocked it in.
  task automatic push_req(input req_t r);
    bit acc = 0;
    in_valid = 1'b1; in_opa = r.opa; in_opb = r.opb; in_cmd = r.cmd;
    in_mode = r.mode; in_cin = r.cin; in_split = r.split;
    for (int g = 0; g < 200 && !acc; g++) begin
      @(negedge clk); acc = (in_ready === 1'b1);
      tick();
    end
    in_valid = 1'b0;
    if (acc) model_q.push_back(r);
    else begin
      checks++; errors++;
      $display("FAIL push_timeout: got in_ready=%b for 200 cycles, want 1", in_ready);
    end
  endtask

  task automatic wait_drain(input int n, input string name);
    for (int g = 0; g < 600; g++) begin
      @(negedge clk);
      if (obs_q.size() >= n && busy === 1'b0 && fifo_cnt === 3'd0) break;
    end
    checks++;
    if (obs_q.size() != n || busy !== 1'b0 || fifo_cnt !== 3'd0) begin
      errors++;
      $display("FAIL %s_drain: got strobes=%0d busy=%b fifo_cnt=%0d, want strobes=%0d busy=0 fifo_cnt=0",
               name, obs_q.size(), busy, fifo_cnt, n);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({opa, opb, cmd, mode, cin, ce, iv, strobe, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got opa=%h opb=%h cmd=%h mode=%b cin=%b ce=%b iv=%b strobe=%b busy=%b, want all 0",
               opa, opb, cmd, mode, cin, ce, iv, strobe, busy);
    end
    checks++;
    if (fifo_cnt !== 3'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_fifo: got fifo_cnt=%0d in_ready=%b, want 0 and 1", fifo_cnt, in_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_add();
    push_req('{opa: 8'h05, opb: 8'h03, cmd: 4'd0, mode: 1'b1, cin: 1'b0, split: 1'b0});
    @(negedge clk);
    checks++;
    if (ce !== 1'b0 || fifo_cnt !== 3'd1) begin
      errors++; $display("FAIL add_no_bypass: got ce=%b fifo_cnt=%0d, want 0 and 1", ce, fifo_cnt);
    end
    @(negedge clk);
    checks++;
    if (ce !== 1'b1 || iv !== 2'b11 || opa !== 8'h05 || opb !== 8'h03 || cmd !== 4'd0 || mode !== 1'b1) begin
      errors++;
      $display("FAIL add_issue_beat: got ce=%b iv=%b opa=%h opb=%h cmd=%h mode=%b, want 1 11 05 03 0 1",
               ce, iv, opa, opb, cmd, mode);
    end
    @(negedge clk);
    checks++;
    if (strobe !== 1'b1 || ce !== 1'b0 || iv !== 2'b00) begin
      errors++; $display("FAIL add_strobe: got strobe=%b ce=%b iv=%b, want 1 0 00", strobe, ce, iv);
    end
    checks++;
    if (alu_res(opa, opb, mode) !== 8'h08) begin
      errors++; $display("FAIL add_result: got %h, want 08", alu_res(opa, opb, mode));
    end
    @(negedge clk);
    checks++;
    if (strobe !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL add_strobe_pulse: got strobe=%b busy=%b, want 0 0", strobe, busy);
    end
    tick();
    obs_q.delete(); model_q.delete();
  endtask

  task automatic test_mul_latency();
    push_req('{opa: 8'h03, opb: 8'h04, cmd: 4'd9, mode: 1'b1, cin: 1'b0, split: 1'b0});
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ce !== 1'b1 || iv !== 2'b11 || cmd !== 4'd9) begin
      errors++; $display("FAIL mul_issue_beat: got ce=%b iv=%b cmd=%h, want 1 11 9", ce, iv, cmd);
    end
    @(negedge clk);
    checks++;
    if (strobe !== 1'b0 || iv !== 2'b00) begin
      errors++; $display("FAIL mul_no_early_strobe: got strobe=%b iv=%b, want 0 00", strobe, iv);
    end
    @(negedge clk);
    checks++;
    if (strobe !== 1'b1) begin
      errors++; $display("FAIL mul_strobe: got strobe=%b, want 1", strobe);
    end
    @(negedge clk);
    checks++;
    if (strobe !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mul_strobe_pulse: got strobe=%b busy=%b, want 0 0", strobe, busy);
    end
    tick();
    obs_q.delete(); model_q.delete();
  endtask

  task automatic test_split();
    push_req('{opa: 8'hAA, opb: 8'h0F, cmd: 4'd0, mode: 1'b0, cin: 1'b0, split: 1'b1});
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ce !== 1'b1 || iv !== 2'b01 || opa !== 8'hAA || opb !== 8'h04) begin
      errors++;
      $display("FAIL split_beat_a: got ce=%b iv=%b opa=%h opb=%h, want 1 01 aa 04(held)", ce, iv, opa, opb);
    end
    @(negedge clk);
    checks++;
    if (ce !== 1'b1 || iv !== 2'b10 || opa !== 8'hAA || opb !== 8'h0F) begin
      errors++;
      $display("FAIL split_beat_b: got ce=%b iv=%b opa=%h opb=%h, want 1 10 aa 0f", ce, iv, opa, opb);
    end
    @(negedge clk);
    checks++;
    if (strobe !== 1'b1 || ce !== 1'b0) begin
      errors++; $display("FAIL split_strobe: got strobe=%b ce=%b, want 1 0", strobe, ce);
    end
    checks++;
    if (alu_res(opa, opb, mode) !== 8'h0A) begin
      errors++; $display("FAIL split_result: got %h, want 0a", alu_res(opa, opb, mode));
    end
    @(negedge clk);
    checks++;
    if (strobe !== 1'b0) begin
      errors++; $display("FAIL split_strobe_pulse: got strobe=%b, want 0", strobe);
    end
    tick();
    obs_q.delete(); model_q.delete();
  endtask

  task automatic test_fill_backpressure();
    req_t reqs[6];
    bit   done = 0, saw_full = 0, rose = 0;
    int   viol = 0;
    int   n;
    foreach (reqs[i]) reqs[i] = rand_req(0, 0);
    fork
      begin
        for (int i = 0; i < 6; i++) push_req(reqs[i]);
        done = 1;
      end
      begin
        for (int g = 0; g < 300 && !done; g++) begin
          @(negedge clk);
          if (in_ready !== (fifo_cnt != 3'd4)) viol++;
          if (fifo_cnt === 3'd4) saw_full = 1;
          else if (saw_full && in_ready === 1'b1) rose = 1;
        end
      end
    join
    checks++;
    if (viol != 0 || !saw_full || !rose) begin
      errors++;
      $display("FAIL fill_ready: got ready_violations=%0d saw_full=%0b ready_rose=%0b, want 0 1 1", viol, saw_full, rose);
    end
    wait_drain(6, "fill");
    n = (obs_q.size() < model_q.size()) ? obs_q.size() : model_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i].r !== model_q[i] || obs_q[i].lat != lat_of(model_q[i])) begin
        errors++;
        $display("FAIL fill_op%0d: got req=%h lat=%0d, want req=%h lat=%0d",
                 i, obs_q[i].r, obs_q[i].lat, model_q[i], lat_of(model_q[i]));
      end
      if (i > 0) begin
        checks++;
        if (obs_q[i].first_cyc - obs_q[i-1].first_cyc != lat_of(model_q[i-1]) + 2) begin
          errors++;
          $display("FAIL fill_spacing%0d: got %0d cycles, want %0d", i,
                   obs_q[i].first_cyc - obs_q[i-1].first_cyc, lat_of(model_q[i-1]) + 2);
        end
      end
    end
    obs_q.delete(); model_q.delete();
  endtask

  task automatic test_reset_mid_op();
    req_t p0;
    int   beats_before, n;
    p0 = rand_req(0, 0);
    p0.split = 1'b1; p0.mode = 1'b1; p0.cmd = 4'd9;
    push_req(p0);
    for (int i = 0; i < 3; i++) push_req(rand_req(1, 1));
    checks++;
    if (fifo_cnt !== 3'd3 || busy !== 1'b1 || ce !== 1'b0 || iv !== 2'b00 || strobe !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre_wait: got fifo_cnt=%0d busy=%b ce=%b iv=%b strobe=%b, want 3 1 0 00 0",
               fifo_cnt, busy, ce, iv, strobe);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({opa, opb, cmd, mode, cin, ce, iv, strobe, busy} !== '0) begin
      errors++;
      $display("FAIL rst_async_outputs: got opa=%h opb=%h cmd=%h mode=%b cin=%b busy=%b, want all 0",
               opa, opb, cmd, mode, cin, busy);
    end
    checks++;
    if (fifo_cnt !== 3'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_async_fifo: got fifo_cnt=%0d in_ready=%b, want 0 1", fifo_cnt, in_ready);
    end
    beats_before = beat_cnt;
    repeat (2) tick();
    rst_n = 1'b1;
    model_q.delete();
    repeat (8) tick();
    checks++;
    if (obs_q.size() != 0 || stray_strobe != 0 || beat_cnt != beats_before) begin
      errors++;
      $display("FAIL rst_discard: got strobes=%0d stray=%0d new_beats=%0d, want 0 0 0",
               obs_q.size(), stray_strobe, beat_cnt - beats_before);
    end
    push_req(rand_req(1, 1));
    wait_drain(1, "rst_next");
    n = (obs_q.size() < 1) ? obs_q.size() : 1;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i].r !== model_q[i] || obs_q[i].lat != lat_of(model_q[i])) begin
        errors++;
        $display("FAIL rst_next_op: got req=%h lat=%0d, want req=%h lat=%0d",
                 obs_q[i].r, obs_q[i].lat, model_q[i], lat_of(model_q[i]));
      end
    end
    obs_q.delete(); model_q.delete();
  endtask

  task automatic test_push_pop_same();
    req_t c;
    int   n;
    push_req(rand_req(0, 1));
    push_req(rand_req(0, 1));
    c = rand_req(0, 1);
    in_valid = 1'b1; in_opa = c.opa; in_opb = c.opb; in_cmd = c.cmd;
    in_mode = c.mode; in_cin = c.cin; in_split = c.split;
    @(negedge clk);
    checks++;
    if (fifo_cnt !== 3'd2 || ce !== 1'b1 || iv !== 2'b11) begin
      errors++;
      $display("FAIL pushpop_setup: got fifo_cnt=%0d ce=%b iv=%b, want 2 1 11", fifo_cnt, ce, iv);
    end
    tick();
    in_valid = 1'b0;
    model_q.push_back(c);
    @(negedge clk);
    checks++;
    if (fifo_cnt !== 3'd2) begin
      errors++; $display("FAIL pushpop_count: got fifo_cnt=%0d, want 2", fifo_cnt);
    end
    tick();
    for (int i = 0; i < 3; i++) push_req(rand_req(1, 1));
    wait_drain(6, "pushpop");
    n = (obs_q.size() < model_q.size()) ? obs_q.size() : model_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i].r !== model_q[i]) begin
        errors++; $display("FAIL pushpop_order%0d: got req=%h, want req=%h", i, obs_q[i].r, model_q[i]);
      end
    end
    obs_q.delete(); model_q.delete();
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 40; i++) begin
      push_req(rand_req(1, 1));
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_drain(40, "random");
    n = (obs_q.size() < model_q.size()) ? obs_q.size() : model_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i].r !== model_q[i] || obs_q[i].lat != lat_of(model_q[i])) begin
        errors++;
        $display("FAIL random_op%0d: got req=%h lat=%0d, want req=%h lat=%0d",
                 i, obs_q[i].r, obs_q[i].lat, model_q[i], lat_of(model_q[i]));
      end
      checks++;
      if (!obs_q[i].opb_held || !obs_q[i].opa_held || !obs_q[i].held_at_strobe || obs_q[i].gap < 1) begin
        errors++;
        $display("FAIL random_hold%0d: got opb_held=%0b opa_held=%0b held_at_strobe=%0b gap=%0d, want 1 1 1 >=1",
                 i, obs_q[i].opb_held, obs_q[i].opa_held, obs_q[i].held_at_strobe, obs_q[i].gap);
      end
    end
    checks++;
    if (bad_bus != 0 || stray_strobe != 0) begin
      errors++;
      $display("FAIL bus_protocol: got bad_beats=%0d stray_strobes=%0d, want 0 0", bad_bus, stray_strobe);
    end
    obs_q.delete(); model_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_mul_latency();
    test_split();
    test_fill_backpressure();
    test_reset_mid_op();
    test_push_pop_same();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
